// File: rtl/abl_unit.sv
// Address-bus-low stage: selects a base and an offset, adds them with a carry-in,
// and registers the result with its carry out. It also holds the program counter low byte.
module abl_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rdy,
    input  logic [7:0] DB,
    input  logic [7:0] REG,
    input  logic [5:0] op,
    input  logic [1:0] vec,
    input  logic       ld_pc,
    input  logic       inc_pc,
    output logic [7:0] ADL,
    output logic [7:0] ABL,
    output logic [7:0] PCL,
    output logic       CO
);

    typedef enum logic [1:0] {BASE_ZERO = 2'b00, BASE_ABL = 2'b01, BASE_PCL = 2'b10, BASE_DB = 2'b11} base_sel_e;
    typedef enum logic [1:0] {OFS_ZERO = 2'b00, OFS_REG = 2'b01, OFS_DEC = 2'b10, OFS_VEC = 2'b11} ofs_sel_e;
    typedef enum logic [1:0] {CI_ZERO = 2'b00, CI_ONE = 2'b01, CI_CARRY = 2'b10, CI_HOLD = 2'b11} ci_mode_e;

    logic [7:0] abl_q, abl_d;
    logic [7:0] pcl_q, pcl_d;
    logic       co_q, co_d;
    logic [7:0] base, offset, vec_byte;
    logic       ci;
    logic [8:0] sum;

    always_comb begin
        // NOTE: every signal gets a default before the case statements, so no path leaves it unassigned and no latch is inferred.
        base     = 8'h00;
        offset   = 8'h00;
        ci       = 1'b0;
        vec_byte = 8'hFE;

        unique case (vec)
            2'b01:   vec_byte = 8'hFA;
            2'b10:   vec_byte = 8'hFC;
            default: vec_byte = 8'hFE;
        endcase

        unique case (base_sel_e'(op[5:4]))
            BASE_ZERO: base = 8'h00;
            BASE_ABL:  base = abl_q;
            BASE_PCL:  base = pcl_q;
            BASE_DB:   base = DB;
        endcase

        // Adding FF with ci is a decrement; the carry out then reads as "no borrow".
        unique case (ofs_sel_e'(op[3:2]))
            OFS_ZERO: offset = 8'h00;
            OFS_REG:  offset = REG;
            OFS_DEC:  offset = 8'hFF;
            OFS_VEC:  offset = vec_byte;
        endcase

        unique case (ci_mode_e'(op[1:0]))
            CI_ZERO:  ci = 1'b0;
            CI_ONE:   ci = 1'b1;
            CI_CARRY: ci = co_q;
            CI_HOLD:  ci = 1'b0;
        endcase

        sum = {1'b0, base} + {1'b0, offset} + {8'b0, ci};
    end

    always_comb begin
        abl_d = abl_q;
        co_d  = co_q;
        pcl_d = pcl_q;
        if (rdy) begin
            abl_d = sum[7:0];
            if (ci_mode_e'(op[1:0]) != CI_HOLD) begin
                co_d = sum[8];
            end
            if (ld_pc) begin
                pcl_d = abl_q + {7'b0, inc_pc};
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values (PCL sees the old ABL).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abl_q <= 8'hFC;
            co_q  <= 1'b0;
            pcl_q <= 8'h00;
        end else begin
            abl_q <= abl_d;
            co_q  <= co_d;
            pcl_q <= pcl_d;
        end
    end

    assign ADL = (rdy && rst_n) ? sum[7:0] : abl_q;
    assign ABL = abl_q;
    assign PCL = pcl_q;
    assign CO  = co_q;

endmodule

// File: tb/tb_abl_unit.sv
// Self-checking bench for abl_unit: directed scenarios plus random steps,
// compared against an arithmetic reference model.
module tb_abl_unit;

    logic       clk;
    logic       rst_n;
    logic       rdy;
    logic [7:0] DB;
    logic [7:0] REG;
    logic [5:0] op;
    logic [1:0] vec;
    logic       ld_pc;
    logic       inc_pc;
    logic [7:0] ADL;
    logic [7:0] ABL;
    logic [7:0] PCL;
    logic       CO;

    int checks = 0;
    int errors = 0;

    // Reference state
    int m_abl;
    int m_co;
    int m_pcl;

    abl_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .rdy    (rdy),
        .DB     (DB),
        .REG    (REG),
        .op     (op),
        .vec    (vec),
        .ld_pc  (ld_pc),
        .inc_pc (inc_pc),
        .ADL    (ADL),
        .ABL    (ABL),
        .PCL    (PCL),
        .CO     (CO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int ref_sum(input int o, input int abl, input int pcl, input int db,
                                   input int rg, input int v, input int co);
        int b, f, c;
        case (o / 16)
            0:       b = 0;
            1:       b = abl;
            2:       b = pcl;
            default: b = db;
        endcase
        case ((o / 4) % 4)
            0:       f = 0;
            1:       f = rg;
            2:       f = 255;
            default: f = (v == 1) ? 250 : (v == 2) ? 252 : 254;
        endcase
        c = (o % 4 == 1) ? 1 : (o % 4 == 2) ? co : 0;
        return b + f + c;
    endfunction

    task automatic model_reset();
        m_abl = 'hFC;
        m_co  = 0;
        m_pcl = 0;
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, ".ABL"}, {1'b0, ABL}, 9'(m_abl));
        chk({tag, ".CO"},  {8'b0, CO},  9'(m_co));
        chk({tag, ".PCL"}, {1'b0, PCL}, 9'(m_pcl));
    endtask

    // Called just after a rising edge; drives inputs, checks ADL, clocks once, checks registers.
    task automatic step(input logic r, input logic [5:0] o, input logic [7:0] d, input logic [7:0] rg,
                        input logic [1:0] v, input logic lp, input logic ip, input string tag);
        int s;
        rdy = r; op = o; DB = d; REG = rg; vec = v; ld_pc = lp; inc_pc = ip;
        #1;
        s = ref_sum(int'(o), m_abl, m_pcl, int'(d), int'(rg), int'(v), m_co);
        chk({tag, ".ADL"}, {1'b0, ADL}, 9'(r ? s % 256 : m_abl));
        @(posedge clk);
        if (r) begin
            if (lp) m_pcl = (m_abl + int'(ip)) % 256;
            m_abl = s % 256;
            if (o % 4 != 3) m_co = s / 256;
        end
        #1;
        chk_regs(tag);
    endtask

    initial begin
        rst_n = 1'b0; rdy = 1'b1; DB = 8'h5A; REG = 8'h33; op = 6'b011101;
        vec = 2'b00; ld_pc = 1'b1; inc_pc = 1'b1;
        model_reset();

        // Reset state, with clock edges and rdy=1 while held
        @(posedge clk); #3;
        chk("rst.ADL", {1'b0, ADL}, 9'h0FC);
        chk_regs("rst");
        @(posedge clk); #3;
        rst_n = 1'b1;
        #1;

        // First edge after release evaluates normally
        step(1, 6'b110000, 8'h34, 8'h00, 2'b00, 0, 0, "load34");
        chk("load34.const", {1'b0, ABL}, 9'h034);

        // Index page cross, then carry propagation
        step(1, 6'b110000, 8'hF0, 8'h00, 2'b00, 0, 0, "setF0");
        step(1, 6'b010100, 8'h00, 8'h20, 2'b00, 0, 0, "xcross");
        chk("xcross.ABL", {1'b0, ABL}, 9'h010);
        chk("xcross.CO", {8'b0, CO}, 9'h001);
        step(1, 6'b010010, 8'h00, 8'h00, 2'b00, 0, 0, "xcarry");
        chk("xcarry.ABL", {1'b0, ABL}, 9'h011);
        chk("xcarry.CO", {8'b0, CO}, 9'h000);

        // Decrement with borrow
        step(1, 6'b110000, 8'h00, 8'h00, 2'b00, 0, 0, "set00");
        step(1, 6'b011000, 8'h00, 8'h00, 2'b00, 0, 0, "dec00");
        chk("dec00.ABL", {1'b0, ABL}, 9'h0FF);
        chk("dec00.CO", {8'b0, CO}, 9'h000);
        step(1, 6'b110000, 8'h05, 8'h00, 2'b00, 0, 0, "set05");
        step(1, 6'b011000, 8'h00, 8'h00, 2'b00, 0, 0, "dec05");
        chk("dec05.ABL", {1'b0, ABL}, 9'h004);
        chk("dec05.CO", {8'b0, CO}, 9'h001);

        // Vectors
        step(1, 6'b001101, 8'h00, 8'h00, 2'b01, 0, 0, "vnmi");
        chk("vnmi.ABL", {1'b0, ABL}, 9'h0FB);
        step(1, 6'b001101, 8'h00, 8'h00, 2'b10, 0, 0, "vrst");
        chk("vrst.ABL", {1'b0, ABL}, 9'h0FD);
        step(1, 6'b001101, 8'h00, 8'h00, 2'b11, 0, 0, "virq");
        chk("virq.ABL", {1'b0, ABL}, 9'h0FF);

        // PCL load: old ABL into PCL, new sum into ABL on the same edge
        step(1, 6'b110000, 8'h42, 8'h00, 2'b00, 0, 0, "set42");
        step(1, 6'b110000, 8'hFF, 8'h00, 2'b00, 1, 0, "pcl42");
        chk("pcl42.PCL", {1'b0, PCL}, 9'h042);
        step(1, 6'b100001, 8'h00, 8'h00, 2'b00, 1, 1, "pclwrap");
        chk("pclwrap.PCL", {1'b0, PCL}, 9'h000);
        chk("pclwrap.ABL", {1'b0, ABL}, 9'h043);
        step(1, 6'b100001, 8'h00, 8'h00, 2'b00, 0, 1, "pclhold");
        chk("pclhold.PCL", {1'b0, PCL}, 9'h000);

        // Carry hold mode keeps CO
        step(1, 6'b110000, 8'hF0, 8'h00, 2'b00, 0, 0, "setF0b");
        step(1, 6'b010100, 8'h00, 8'h20, 2'b00, 0, 0, "co1");
        step(1, 6'b110011, 8'h01, 8'h00, 2'b00, 0, 0, "cohold");
        chk("cohold.CO", {8'b0, CO}, 9'h001);

        // Stall for three cycles, then resume with the same op
        for (int i = 0; i < 3; i++)
            step(0, 6'($urandom), 8'($urandom), 8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), "stall");
        step(1, 6'b010100, 8'h00, 8'h20, 2'b00, 0, 0, "resume");

        // Randomized traffic
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(9) != 0), 6'($urandom), 8'($urandom), 8'($urandom),
                 2'($urandom), 1'($urandom), 1'($urandom), "rand");

        // Asynchronous reset in the middle of a cycle
        step(1, 6'b110000, 8'h77, 8'h00, 2'b00, 1, 1, "prerst");
        rdy = 1'b1; op = 6'b010101; ld_pc = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst.ADL", {1'b0, ADL}, 9'h0FC);
        chk_regs("midrst");
        @(posedge clk); #1;
        chk_regs("midrst.hold");
        #2;
        rst_n = 1'b1;
        step(1, 6'b110000, 8'h34, 8'h00, 2'b00, 0, 0, "post34");
        chk("post34.const", {1'b0, ABL}, 9'h034);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/abl_unit.md
ABL_UNIT -- requirements
Module: abl_unit

Interface
REQ-001 The module SHALL use one clock and an asynchronous, active-low reset, with the ports defined below.
REQ-002 clk  input  1  rising-edge clock for all registers.
REQ-003 rst_n  input  1  asynchronous reset, active low.
REQ-004 rdy  input  1  advance enable: 1 = registers update on the clock edge, 0 = all registers hold.
REQ-005 DB  input  8  data bus read value.
REQ-006 REG  input  8  index or stack register value from the register file.
REQ-007 op  input  6  address-low operation: op[5:4] selects the base, op[3:2] the offset, op[1:0] the carry mode.
REQ-008 vec  input  2  interrupt vector select.
REQ-009 ld_pc  input  1  load PCL from the current ABL.
REQ-010 inc_pc  input  1  increment while loading PCL.
REQ-011 ADL  output  8  unregistered next address-bus-low value.
REQ-012 ABL  output  8  registered address-bus-low value.
REQ-013 PCL  output  8  program counter low byte.
REQ-014 CO  output  1  registered carry out, which feeds CI of the address-high stage.

Function
REQ-015 The base SHALL be selected by op[5:4]: 00 = 8'h00, 01 = ABL, 10 = PCL, 11 = DB.
REQ-016 The offset SHALL be selected by op[3:2]: 00 = 8'h00, 01 = REG, 10 = 8'hFF, 11 = vector byte.
REQ-017 The vector byte SHALL be selected by vec: 01 = 8'hFA (NMI), 10 = 8'hFC (reset), 00 and 11 = 8'hFE (IRQ/BRK).
REQ-018 The carry-in ci SHALL be selected by op[1:0]: 00 = 0, 01 = 1, 10 = current CO register, 11 = 0 with CO held (no update).
REQ-019 sum SHALL be the 9-bit value base + offset + ci, zero-extended.
REQ-020 When rdy=1, ADL SHALL equal sum[7:0]; when rdy=0, ADL SHALL equal ABL.
REQ-021 On each rising clk edge with rdy=1, ABL SHALL be loaded with sum[7:0].
REQ-022 On each rising clk edge with rdy=1 and op[1:0]!=11, CO SHALL be loaded with sum[8].
REQ-023 Offset 8'hFF plus ci is a decrement with borrow: CO=1 SHALL mean no borrow, matching the "-1 + CI" mode of the address-high stage.
REQ-024 On a rising edge with rdy=1 and ld_pc=1, PCL SHALL be loaded with (ABL + inc_pc) mod 256, using the pre-edge ABL; no carry is produced.
REQ-025 PCL SHALL be unchanged when ld_pc=0 or rdy=0.
REQ-026 Latency: ADL is combinational from the inputs in the same cycle; ABL and CO are valid one clock after ADL.
REQ-027 Wrap-around: the base + offset addition SHALL wrap modulo 256 on ABL, with the overflow reported only via CO; there is no zero-page special case.
REQ-028 Simultaneous events: ld_pc and an ABL update in the same edge SHALL use the old ABL for PCL and the new sum for ABL.
REQ-029 With op[1:0]=10, the CO used as ci SHALL be the pre-edge value, and CO SHALL then be updated with the new carry.
REQ-030 rdy=0 SHALL freeze ABL, CO and PCL regardless of op, ld_pc and inc_pc.

Reset
REQ-031 While rst_n=0, ABL SHALL be 8'hFC, CO 0 and PCL 8'h00, asynchronously and independent of clk and rdy.
REQ-032 Reset assertion mid-operation SHALL override any pending update.
REQ-033 The first clock edge after rst_n rises SHALL evaluate normally.
REQ-034 While rst_n=0, ADL SHALL equal ABL (8'hFC).

Verification
REQ-035 Scenario: assert rst_n=0 mid-cycle -> ABL=FC, CO=0, PCL=00 immediately; release, then op=11_00_00 with DB=34 -> ABL=34 after one edge.
REQ-036 Scenario: index page cross, ABL=F0, REG=20, op=01_01_00 -> ADL=10, then ABL=10, CO=1; next op=01_00_10 with REG=00 -> ABL=11, CO=0.
REQ-037 Scenario: decrement, ABL=00, op=01_10_00 -> ABL=FF, CO=0 (borrow); ABL=05 with the same op -> ABL=04, CO=1.
REQ-038 Scenario: vectors, op=00_11_01 with vec=01 -> ABL=FB; with vec=10 -> ABL=FD; with vec=11 -> ABL=FF (from the FA/FC/FE vector bytes plus ci=1).
REQ-039 Scenario: ABL=FF, ld_pc=1, inc_pc=1, op=10_00_01 -> PCL=00 (wrap) and ABL=old PCL+1 in the same edge; with ld_pc=0, PCL unchanged.
REQ-040 Scenario: rdy=0 for 3 cycles with random op/DB/ld_pc -> ABL, CO, PCL constant and ADL=ABL; rdy=1 resumes with the same op result.
